mem_req_scheduler: RTL and testbench

- Arbitrates between two requesters of the SDRAM memory coupler: write-buffer drain (stores) and cache-line fill (loads on cache miss).
- Loads have priority by default. Stores are forced through after a bounded number of consecutive loads, or immediately when the write buffer is full.
- Drives the coupler's one-hot store/load triggers and latched load address, tracks the coupler's st_busy/ld_busy handshake to completion, and returns a done pulse to the winning requester.

---
 rtl/mem_sched_pkg.sv | 21 ++
 rtl/mem_sched_arb.sv | 18 +
 rtl/mem_req_scheduler.sv | 173 +++++++++++++++++
 tb/tb_mem_req_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sched_pkg.sv
// Shared types and constants for the SDRAM coupler request scheduler.
// Holds the FSM state encoding and the cache-line address helper.
package mem_sched_pkg;

  localparam int LINE_OFFSET_BITS = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ST_REQ = 3'd1,
    ST_RUN = 3'd2,
    LD_REQ = 3'd3,
    LD_RUN = 3'd4,
    COOL   = 3'd5
  } sched_state_e;

  // True when both addresses fall in the same cache line.
  function automatic logic same_line(input logic [31:0] a, input logic [31:0] b);
    return a[31:LINE_OFFSET_BITS] == b[31:LINE_OFFSET_BITS];
  endfunction

endpackage

// File: rtl/mem_sched_arb.sv
// Combinational grant decision between write-buffer drain and cache-line fill.
// Loads win by default; a store wins on full buffer, streak limit, no load, or RAW hit.
module mem_sched_arb (
  input  logic wb_req,
  input  logic wb_full,
  input  logic miss_req,
  input  logic streak_hit,
  input  logic raw_hit,
  output logic grant_st,
  output logic grant_ld
);

  always_comb begin
    grant_st = wb_req & (wb_full | streak_hit | ~miss_req | raw_hit);
    grant_ld = miss_req & ~grant_st;
  end

endmodule

// File: rtl/mem_req_scheduler.sv
// Arbitrates stores and line fills onto the SDRAM coupler and tracks its busy handshake.
// Optional MEM_RAW_CHECK_EN: a store to the missing line is drained before the fill.
module mem_req_scheduler
  import mem_sched_pkg::*;
#(
  parameter int MAX_LD_STREAK = 4,
  parameter int STREAK_W      = 3,
  parameter int TRIG_TIMEOUT  = 8,
  parameter int TMO_W         = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_req,
  input  logic        wb_full,
  input  logic [31:0] wb_addr,
  output logic        wb_done,
  input  logic        miss_req,
  input  logic [31:0] miss_addr,
  output logic        miss_done,
  output logic        store_trigger,
  output logic        load_trigger,
  output logic [31:0] ld_addr,
  input  logic        st_busy,
  input  logic        ld_busy,
  output logic        sched_err
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LD_STREAK);
  localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TRIG_TIMEOUT - 1);

  sched_state_e        state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                st_trig_q, st_trig_d;
  logic                ld_trig_q, ld_trig_d;
  logic [31:0]         ld_addr_q, ld_addr_d;
  logic                wb_done_q, wb_done_d;
  logic                miss_done_q, miss_done_d;
  logic                err_q, err_d;

  logic streak_hit;
  logic raw_hit;
  logic grant_st;
  logic grant_ld;

  assign streak_hit = (streak_q == STREAK_MAX);

`ifdef MEM_RAW_CHECK_EN
  assign raw_hit = miss_req & wb_req & same_line(miss_addr, wb_addr);
`else
  logic unused_wb_addr;
  assign raw_hit        = 1'b0;
  assign unused_wb_addr = ^wb_addr;
`endif

  mem_sched_arb u_arb (
    .wb_req     (wb_req),
    .wb_full    (wb_full),
    .miss_req   (miss_req),
    .streak_hit (streak_hit),
    .raw_hit    (raw_hit),
    .grant_st   (grant_st),
    .grant_ld   (grant_ld)
  );

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves it unassigned and infers a latch.
    state_d     = state_q;
    streak_d    = streak_q;
    tmo_d       = '0;
    st_trig_d   = st_trig_q;
    ld_trig_d   = ld_trig_q;
    ld_addr_d   = ld_addr_q;
    wb_done_d   = 1'b0;
    miss_done_d = 1'b0;
    err_d       = err_q;

    unique case (state_q)
      IDLE: begin
        if (!wb_req) streak_d = '0;
        if (!st_busy && !ld_busy) begin
          if (grant_st) begin
            st_trig_d = 1'b1;
            streak_d  = '0;
            state_d   = ST_REQ;
          end else if (grant_ld) begin
            ld_trig_d = 1'b1;
            ld_addr_d = miss_addr;
            if (wb_req && !streak_hit) streak_d = streak_q + 1'b1;
            state_d   = LD_REQ;
          end
        end
      end

      ST_REQ: begin
        if (st_busy) begin
          st_trig_d = 1'b0;
          state_d   = ST_RUN;
        end else if (tmo_q == TMO_LAST) begin
          st_trig_d = 1'b0;
          err_d     = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      LD_REQ: begin
        if (ld_busy) begin
          ld_trig_d = 1'b0;
          state_d   = LD_RUN;
        end else if (tmo_q == TMO_LAST) begin
          ld_trig_d = 1'b0;
          err_d     = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      ST_RUN: begin
        if (!st_busy) begin
          wb_done_d = 1'b1;
          state_d   = COOL;
        end
      end

      LD_RUN: begin
        if (!ld_busy) begin
          miss_done_d = 1'b1;
          state_d     = COOL;
        end
      end

      // Gives the coupler one cycle to settle back to idle before the next trigger.
      COOL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      tmo_q       <= '0;
      st_trig_q   <= 1'b0;
      ld_trig_q   <= 1'b0;
      ld_addr_q   <= '0;
      wb_done_q   <= 1'b0;
      miss_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      tmo_q       <= tmo_d;
      st_trig_q   <= st_trig_d;
      ld_trig_q   <= ld_trig_d;
      ld_addr_q   <= ld_addr_d;
      wb_done_q   <= wb_done_d;
      miss_done_q <= miss_done_d;
      err_q       <= err_d;
    end
  end

  assign store_trigger = st_trig_q;
  assign load_trigger  = ld_trig_q;
  assign ld_addr       = ld_addr_q;
  assign wb_done       = wb_done_q;
  assign miss_done     = miss_done_q;
  assign sched_err     = err_q;

endmodule

// File: tb/tb_mem_req_scheduler.sv
// Self-checking bench for mem_req_scheduler: directed scenarios plus random traffic
// against a transaction-phase reference model and a behavioural coupler model.
module tb_mem_req_scheduler;

  localparam int MAX_LD_STREAK = 4;
  localparam int TRIG_TIMEOUT  = 8;
  localparam int WB_DEPTH      = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wb_req = 1'b0, wb_full = 1'b0, miss_req = 1'b0;
  logic [31:0] wb_addr = '0, miss_addr = '0;
  logic        st_busy = 1'b0, ld_busy = 1'b0;
  logic        wb_done, miss_done, store_trigger, load_trigger, sched_err;
  logic [31:0] ld_addr;

  always #5 clk = ~clk;

  mem_req_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .wb_req        (wb_req),
    .wb_full       (wb_full),
    .wb_addr       (wb_addr),
    .wb_done       (wb_done),
    .miss_req      (miss_req),
    .miss_addr     (miss_addr),
    .miss_done     (miss_done),
    .store_trigger (store_trigger),
    .load_trigger  (load_trigger),
    .ld_addr       (ld_addr),
    .st_busy       (st_busy),
    .ld_busy       (ld_busy),
    .sched_err     (sched_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: which transaction is in flight and which handshake step it awaits.
  int          m_phase;   // 0 free, 1 awaiting busy rise, 2 awaiting busy fall, 3 settle
  bit          m_st;
  int          m_age;
  int          m_streak;
  logic        e_st, e_ld, e_wbd, e_md, e_err;
  logic [31:0] e_addr;

  task automatic model_clear();
    m_phase = 0; m_st = 0; m_age = 0; m_streak = 0;
    e_st = 0; e_ld = 0; e_wbd = 0; e_md = 0; e_err = 0; e_addr = '0;
  endtask

  task automatic model_step();
    bit st_win, raw, busy_now;
    e_wbd = 0;
    e_md  = 0;
    busy_now = m_st ? st_busy : ld_busy;
    case (m_phase)
      0: begin
        if (!wb_req) m_streak = 0;
        if (!st_busy && !ld_busy) begin
          raw = 0;
`ifdef MEM_RAW_CHECK_EN
          raw = miss_req && wb_req && ((miss_addr >> 4) == (wb_addr >> 4));
`endif
          st_win = wb_req && (wb_full || m_streak >= MAX_LD_STREAK || !miss_req || raw);
          if (st_win) begin
            e_st = 1; m_streak = 0; m_st = 1; m_age = 0; m_phase = 1;
          end else if (miss_req) begin
            e_ld = 1; e_addr = miss_addr; m_st = 0; m_age = 0; m_phase = 1;
            if (wb_req && m_streak < MAX_LD_STREAK) m_streak++;
          end
        end
      end
      1: begin
        m_age++;
        if (busy_now) begin
          e_st = 0; e_ld = 0; m_phase = 2;
        end else if (m_age == TRIG_TIMEOUT) begin
          e_st = 0; e_ld = 0; e_err = 1; m_phase = 0;
        end
      end
      2: if (!busy_now) begin
        if (m_st) e_wbd = 1; else e_md = 1;
        m_phase = 3;
      end
      default: m_phase = 0;
    endcase
  endtask

  // Stimulus state: write buffer, miss source, coupler model, grant log.
  logic [31:0] wb_q[$];
  bit          rand_en = 0, miss_auto = 0, cpl_rand = 0, cpl_dead = 0;
  int          cpl_state = 0, cpl_cnt = 0, cpl_rise = 2, cpl_hold = 12, spur_n = 0;
  bit          cpl_st = 0;
  bit          prev_st = 0, prev_ld = 0;
  logic [15:0] seq = '0;
  int          ngr = 0, nst_gr = 0, nst_done = 0, nld_done = 0;

  task automatic update_wb();
    wb_req  = (wb_q.size() > 0);
    wb_full = (wb_q.size() >= WB_DEPTH);
    wb_addr = (wb_q.size() > 0) ? wb_q[0] : 32'h0;
  endtask

  task automatic requester_drive();
    if (wb_done) begin
      if (wb_q.size() > 0) void'(wb_q.pop_front());
      nst_done++;
    end
    if (miss_done) begin
      nld_done++;
      if (miss_auto) miss_addr = miss_addr + 32'h40;
      else miss_req = 0;
    end
    if (rand_en) begin
      if (wb_q.size() < WB_DEPTH && $urandom_range(5, 0) == 0) wb_q.push_back($urandom);
      if (!miss_req && $urandom_range(4, 0) == 0) begin
        miss_addr = $urandom;
        miss_req  = 1;
      end
    end
    update_wb();
  endtask

  task automatic coupler_drive();
    if (spur_n > 0) spur_n--;
    case (cpl_state)
      0: if (!cpl_dead && (store_trigger || load_trigger)) begin
        cpl_st = store_trigger;
        if (cpl_rand) begin
          cpl_rise = $urandom_range(3, 1);
          cpl_hold = $urandom_range(6, 1);
        end
        cpl_cnt   = cpl_rise;
        cpl_state = 1;
      end
      1: begin
        cpl_cnt--;
        if (cpl_cnt <= 0) begin cpl_state = 2; cpl_cnt = cpl_hold; end
      end
      default: begin
        cpl_cnt--;
        if (cpl_cnt <= 0) cpl_state = 0;
      end
    endcase
    st_busy = (cpl_state == 2 && cpl_st) || spur_n > 0;
    ld_busy = (cpl_state == 2 && !cpl_st);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("store_trigger", store_trigger, e_st);
    check("load_trigger", load_trigger, e_ld);
    check("ld_addr", ld_addr, e_addr);
    check("wb_done", wb_done, e_wbd);
    check("miss_done", miss_done, e_md);
    check("sched_err", sched_err, e_err);
    check("trig_exclusive", store_trigger & load_trigger, 0);
    if (store_trigger && !prev_st) begin seq = {seq[14:0], 1'b1}; ngr++; nst_gr++; end
    if (load_trigger && !prev_ld) begin seq = {seq[14:0], 1'b0}; ngr++; end
    prev_st = store_trigger;
    prev_ld = load_trigger;
    requester_drive();
    coupler_drive();
  endtask

  task automatic do_reset();
    #2 reset = 1;
    #1;
    check("rst_store_trigger", store_trigger, 0);
    check("rst_load_trigger", load_trigger, 0);
    check("rst_ld_addr", ld_addr, 0);
    check("rst_wb_done", wb_done, 0);
    check("rst_miss_done", miss_done, 0);
    check("rst_sched_err", sched_err, 0);
    model_clear();
    cpl_state = 0; spur_n = 0; st_busy = 0; ld_busy = 0;
    miss_req = 0; miss_auto = 0; rand_en = 0;
    wb_q.delete();
    update_wb();
    prev_st = 0; prev_ld = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  function automatic bit all_quiet();
    return wb_q.size() == 0 && !miss_req && cpl_state == 0 && m_phase == 0;
  endfunction

  task automatic drain(input string tag, input int budget);
    int k = 0;
    while (!all_quiet() && k < budget) begin tick(); k++; end
    check(tag, all_quiet(), 1);
  endtask

  task automatic run_grants(input string tag, input int n, input int budget);
    int k = 0;
    while (ngr < n && k < budget) begin tick(); k++; end
    check(tag, (ngr >= n), 1);
  endtask

  initial begin
    int base, k;
    logic raw_exp;
    model_clear();
    do_reset();

    // Load only: address latched, single done, no store.
    base = nld_done;
    miss_addr = 32'h0000_1230;
    miss_req  = 1;
    drain("t1_drain", 100);
    check("t1_ld_addr", ld_addr, 32'h0000_1230);
    check("t1_miss_done_cnt", nld_done - base, 1);
    check("t1_no_store", nst_gr, 0);

    // Simultaneous requests: load first, store next.
    ngr = 0; seq = '0;
    miss_addr = 32'h0000_2000; miss_req = 1;
    wb_q.push_back(32'h0000_5000); update_wb();
    run_grants("t2_budget", 2, 100);
    check("t2_order", seq[1:0], 2'b01);
    drain("t2_drain", 100);

    // Streak limit: four loads, forced store, loads resume.
    ngr = 0; seq = '0;
    wb_q.push_back(32'h0000_9000); wb_q.push_back(32'h0000_9010); update_wb();
    miss_auto = 1; miss_addr = 32'h0000_3000; miss_req = 1;
    run_grants("t3_budget", 6, 300);
    check("t3_sequence", seq[5:0], 6'b000010);
    miss_auto = 0;
    drain("t3_drain", 200);

    // Full write buffer beats a pending load.
    ngr = 0; seq = '0;
    for (int i = 0; i < WB_DEPTH; i++) wb_q.push_back(32'h0000_8000 + 32'(i * 16));
    update_wb();
    miss_addr = 32'h0000_4000; miss_req = 1;
    run_grants("t4_budget", 2, 200);
    check("t4_order", seq[1:0], 2'b10);
    drain("t4_drain", 300);

    // Busy high while idle blocks any grant.
    base = ngr;
    spur_n = 5; st_busy = 1;
    miss_addr = 32'h0000_6000; miss_req = 1;
    repeat (3) tick();
    check("busy_ignored", ngr - base, 0);
    drain("busy_drain", 200);
    check("busy_then_grant", ngr - base, 1);

    // Random traffic with random coupler latencies.
    cpl_rand = 1; rand_en = 1;
    repeat (1500) tick();
    rand_en = 0;
    drain("rand_drain", 600);
    cpl_rand = 0;

    // Handshake timeout: sticky error, no done.
    cpl_rise = 1; cpl_hold = 3; cpl_dead = 1;
    base = nst_done;
    wb_q.push_back(32'h0000_A000); update_wb();
    repeat (12) tick();
    check("t5_err_set", sched_err, 1);
    check("t5_no_wb_done", nst_done - base, 0);
    cpl_dead = 0;
    drain("t5_drain", 200);
    check("t5_err_sticky", sched_err, 1);

    // Reset during load run: outputs clear at once, no done.
    base = nld_done;
    cpl_hold = 20;
    miss_addr = 32'h0000_7000; miss_req = 1;
    k = 0;
    while (!(m_phase == 2 && !m_st) && k < 50) begin tick(); k++; end
    check("t6_reached_run", (m_phase == 2 && !m_st), 1);
    do_reset();
    check("t6_no_miss_done", nld_done - base, 0);

    // Same-line store and miss: store first only with the RAW check built in.
    cpl_hold = 4;
    ngr = 0; seq = '0;
    wb_q.push_back(32'h0000_010C); update_wb();
    miss_addr = 32'h0000_0100; miss_req = 1;
    run_grants("t6_raw_budget", 1, 50);
`ifdef MEM_RAW_CHECK_EN
    raw_exp = 1'b1;
`else
    raw_exp = 1'b0;
`endif
    check("t6_raw_order", seq[0], raw_exp);
    drain("t6_raw_drain", 200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
